// File: rtl/cycle_counter_ctrl_pkg.sv
// Shared types and constants for the cycle counter controller.
package cycle_counter_ctrl_pkg;

   localparam int unsigned CMD_WIDTH = 2;

   typedef enum logic [CMD_WIDTH-1:0] {
      CmdStart = 2'd0,
      CmdStop  = 2'd1,
      CmdClear = 2'd2,
      CmdSnap  = 2'd3
   } cmd_e;

endpackage

// File: rtl/cycle_counter_rr_arb.sv
// Round-robin arbiter: one-hot grant from a request mask, search starts at the pointer.
module cycle_counter_rr_arb #(
   parameter int unsigned NumReq = 4,
   localparam int unsigned IdxW  = $clog2(NumReq)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_i,
   output logic [NumReq-1:0] gnt_o,
   output logic [IdxW-1:0]   gnt_idx_o,
   output logic              gnt_any_o
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] cand;

   // Pick the first requester at or after the pointer, wrapping modulo NumReq.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      cand      = '0;
      for (int k = 0; k < NumReq; k++) begin
         cand = IdxW'((int'(ptr_q) + k) % NumReq);
         if (!gnt_any_o && req_i[cand]) begin
            gnt_any_o   = 1'b1;
            gnt_idx_o   = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

   // Pointer moves past the winner; held when nothing is granted.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any_o) begin
         ptr_d = (gnt_idx_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/cycle_counter_ctrl.sv
// Cycle counter with START/STOP/CLEAR/SNAP commands from several arbitrated requesters
// and a single-entry snapshot output slot.
module cycle_counter_ctrl
   import cycle_counter_ctrl_pkg::*;
#(
   parameter int unsigned NumReq   = 4,
   parameter int unsigned CntWidth = 64,
   localparam int unsigned IdWidth = $clog2(NumReq)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumReq-1:0]        req_valid_i,
   input  logic [2*NumReq-1:0]      req_cmd_i,
   output logic [NumReq-1:0]        req_ready_o,
   output logic                     snap_valid_o,
   input  logic                     snap_ready_i,
   output logic [CntWidth-1:0]      snap_value_o,
   output logic [IdWidth-1:0]       snap_id_o,
   output logic [CntWidth-1:0]      count_o,
   output logic                     running_o,
   output logic                     overflow_o
);

   localparam logic [0:0] StStopped = 1'b0;
   localparam logic [0:0] StRunning = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                snap_valid_q, snap_valid_d;
   logic [CntWidth-1:0] snap_value_q, snap_value_d;
   logic [IdWidth-1:0]  snap_id_q, snap_id_d;

   logic [NumReq-1:0]   eligible;
   logic [NumReq-1:0]   gnt;
   logic [IdWidth-1:0]  gnt_idx;
   logic                gnt_any;
   cmd_e                acc_cmd;
   logic                is_start, is_stop, is_clear, is_snap, inc;

   // SNAP requesters are masked while the slot is full and not draining this cycle.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NumReq; i++) begin
         eligible[i] = req_valid_i[i] && !rst_i &&
                       ((cmd_e'(req_cmd_i[i*CMD_WIDTH +: CMD_WIDTH]) != CmdSnap) ||
                        !snap_valid_q || snap_ready_i);
      end
   end

   cycle_counter_rr_arb #(
      .NumReq (NumReq)
   ) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (eligible),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   // Select and decode the accepted command.
   always_comb begin
      acc_cmd = CmdStart;
      for (int i = 0; i < NumReq; i++) begin
         if (gnt[i]) begin
            acc_cmd = cmd_e'(req_cmd_i[i*CMD_WIDTH +: CMD_WIDTH]);
         end
      end
      is_start = gnt_any && (acc_cmd == CmdStart);
      is_stop  = gnt_any && (acc_cmd == CmdStop);
      is_clear = gnt_any && (acc_cmd == CmdClear);
      is_snap  = gnt_any && (acc_cmd == CmdSnap);
   end

   // FSM, counter and sticky wrap flag next state.
   always_comb begin
      state_d = state_q;
      if (is_start) begin
         state_d = StRunning;
      end else if (is_stop) begin
         state_d = StStopped;
      end

      inc     = (state_q == StRunning) && !is_stop && !is_clear;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (is_clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (inc) begin
         count_d = count_q + 1'b1;
         if (&count_q) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Snapshot slot: capture on SNAP, drain on handshake, refill in the same cycle if both.
   always_comb begin
      snap_valid_d = snap_valid_q;
      snap_value_d = snap_value_q;
      snap_id_d    = snap_id_q;
      if (is_snap) begin
         snap_valid_d = 1'b1;
         snap_value_d = count_q;
         snap_id_d    = gnt_idx;
      end else if (snap_ready_i) begin
         snap_valid_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StStopped;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_value_q <= '0;
         snap_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         snap_valid_q <= snap_valid_d;
         snap_value_q <= snap_value_d;
         snap_id_q    <= snap_id_d;
      end
   end

   // Outputs come straight from registers, except the arbiter grant.
   always_comb begin
      req_ready_o  = gnt;
      snap_valid_o = snap_valid_q;
      snap_value_o = snap_value_q;
      snap_id_o    = snap_id_q;
      count_o      = count_q;
      running_o    = (state_q == StRunning);
      overflow_o   = ovf_q;
   end

endmodule

// File: tb/tb_cycle_counter_ctrl.sv
// Bench for cycle_counter_ctrl: directed scenarios plus random traffic against a
// reference model; snapshots are checked through a scoreboard queue by a monitor.
module tb_cycle_counter_ctrl;

   localparam int unsigned NumReq   = 4;
   localparam int unsigned CntWidth = 8;
   localparam int unsigned Modulus  = 256;

   logic                clk_i;
   logic                rst_i;
   logic [3:0]          req_valid_i;
   logic [7:0]          req_cmd_i;
   logic [3:0]          req_ready_o;
   logic                snap_valid_o;
   logic                snap_ready_i;
   logic [7:0]          snap_value_o;
   logic [1:0]          snap_id_o;
   logic [7:0]          count_o;
   logic                running_o;
   logic                overflow_o;

   cycle_counter_ctrl #(
      .NumReq   (NumReq),
      .CntWidth (CntWidth)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_cmd_i    (req_cmd_i),
      .req_ready_o  (req_ready_o),
      .snap_valid_o (snap_valid_o),
      .snap_ready_i (snap_ready_i),
      .snap_value_o (snap_value_o),
      .snap_id_o    (snap_id_o),
      .count_o      (count_o),
      .running_o    (running_o),
      .overflow_o   (overflow_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      int unsigned val;
      int          id;
   } snap_t;

   snap_t       exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   // Reference model state (values visible on the DUT outputs this cycle).
   bit          m_run  = 0;
   int unsigned m_cnt  = 0;
   bit          m_ovf  = 0;
   bit          m_slot = 0;
   int          m_ptr  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Apply one cycle of stimulus, compare against the model, then advance the model.
   task automatic drive(input logic [3:0] v, input logic [7:0] c, input logic sr,
                        input logic rst);
      int g;
      int cmd;
      @(negedge clk_i);
      req_valid_i  = v;
      req_cmd_i    = c;
      snap_ready_i = sr;
      rst_i        = rst;
      #1;
      g = -1;
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (g < 0 && v[i] && (c[2*i +: 2] != 2'd3 || !m_slot || sr)) g = i;
         end
      end
      chk("ready", req_ready_o, (g >= 0) ? (64'd1 << g) : 0);
      chk("count", count_o, m_cnt);
      chk("running", running_o, m_run);
      chk("overflow", overflow_o, m_ovf);
      chk("snap_valid", snap_valid_o, m_slot);

      if (rst) begin
         m_run = 0; m_cnt = 0; m_ovf = 0; m_slot = 0; m_ptr = 0;
         exp_q.delete();
      end else begin
         cmd = (g >= 0) ? int'(c[2*g +: 2]) : -1;
         if (g >= 0) m_ptr = (g + 1) % 4;
         if (cmd == 3) begin
            exp_q.push_back('{val: m_cnt, id: g});
            m_slot = 1;
         end else if (sr) begin
            m_slot = 0;
         end
         if (cmd == 2) begin
            m_cnt = 0;
            m_ovf = 0;
         end else if (m_run && cmd != 1) begin
            if (m_cnt == Modulus - 1) m_ovf = 1;
            m_cnt = (m_cnt + 1) % Modulus;
         end
         if (cmd == 0) m_run = 1;
         else if (cmd == 1) m_run = 0;
      end
   endtask

   task automatic idle(input int n, input logic sr);
      for (int j = 0; j < n; j++) drive(4'b0000, 8'h00, sr, 1'b0);
   endtask

   task automatic run_to(input int unsigned target);
      int guard;
      guard = 0;
      while (m_cnt != target && guard < 300) begin
         idle(1, 1'b1);
         guard++;
      end
      chk("reach_count_bound", m_cnt, target);
   endtask

   // Monitor: whenever a snapshot is presented, it must match the oldest expected one.
   initial begin
      snap_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (!rst_i && snap_valid_o) begin
            if (exp_q.size() == 0) begin
               chk("snap_unexpected", 1, 0);
            end else begin
               e = exp_q[0];
               chk("snap_value", snap_value_o, e.val);
               chk("snap_id", snap_id_o, e.id);
               if (snap_ready_i) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst_i        = 1'b1;
      req_valid_i  = '0;
      req_cmd_i    = '0;
      snap_ready_i = 1'b0;

      drive(4'b0000, 8'h00, 1'b0, 1'b1);
      drive(4'b1111, 8'h00, 1'b1, 1'b1);

      // START from req0, count up.
      drive(4'b0001, 8'h00, 1'b0, 1'b0);
      idle(12, 1'b0);
      chk("count_after_start", count_o, 11);

      // STOP at 100 from req1, hold, second STOP is a no-op.
      run_to(100);
      drive(4'b0010, 8'b0000_0100, 1'b0, 1'b0);
      idle(20, 1'b0);
      chk("frozen_count", count_o, 100);
      drive(4'b0010, 8'b0000_0100, 1'b0, 1'b0);
      idle(2, 1'b0);

      // All requesters SNAP with sink ready: round-robin rotation.
      drive(4'b0001, 8'h00, 1'b1, 1'b0);
      for (int j = 0; j < 6; j++) drive(4'b1111, 8'hff, 1'b1, 1'b0);
      idle(2, 1'b1);

      // Slot full, sink stalled: CLEAR wins over the masked SNAP until ready rises.
      drive(4'b0001, 8'h03, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) drive(4'b1100, 8'b1011_0000, 1'b0, 1'b0);
      drive(4'b0100, 8'b0011_0000, 1'b1, 1'b0);
      idle(2, 1'b1);

      // Wrap at 8 bits, then CLEAR while running.
      run_to(250);
      idle(8, 1'b1);
      chk("overflow_set", overflow_o, 1);
      drive(4'b0001, 8'h02, 1'b1, 1'b0);
      idle(3, 1'b1);

      // Reset with a pending snapshot, then arbitration restarts at requester 0.
      drive(4'b0010, 8'h0c, 1'b0, 1'b0);
      drive(4'b1111, 8'hff, 1'b1, 1'b1);
      drive(4'b1111, 8'h00, 1'b0, 1'b0);
      idle(2, 1'b1);

      // Random traffic.
      for (int j = 0; j < 500; j++) begin
         logic rst_r;
         rst_r = ($urandom_range(0, 99) == 0);
         drive(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)), rst_r);
      end
      idle(3, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
